// File: rtl/capture_mode_ctrl.sv
// capture_mode_ctrl: measures line/frame timing, classifies 31 kHz vs 15 kHz input and gates capture.
// Defining CAPTURE_MODE_OVERRIDE_EN adds force_en/force_doubler for a forced output mode.

module capture_mode_ctrl #(
  parameter int H_THRESHOLD  = 1200,
  parameter int V_MIN_LINES  = 200,
  parameter int LOCK_FRAMES  = 4,
  parameter int BLANK_FRAMES = 2,
  parameter int WD_WIDTH     = 20
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [11:0] counterX,
  input  logic [11:0] counterY,
`ifdef CAPTURE_MODE_OVERRIDE_EN
  input  logic        force_en,
  input  logic        force_doubler,
`endif
  output logic        line_doubler,
  output logic        capture_en,
  output logic        mode_locked,
  output logic        mode_change,
  output logic [11:0] line_len,
  output logic [11:0] frame_lines
);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_BLANK   = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam logic [12:0]         H_TH_C  = 13'(H_THRESHOLD);
  localparam logic [12:0]         V_MIN_C = 13'(V_MIN_LINES);
  localparam logic [3:0]          LOCK_C  = 4'(LOCK_FRAMES);
  localparam logic [3:0]          BLANK_C = 4'(BLANK_FRAMES);
  localparam logic [WD_WIDTH-1:0] WD_MAX  = {WD_WIDTH{1'b1}};
  localparam logic [WD_WIDTH-1:0] WD_ONE  = {{(WD_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [11:0] sat12(input logic [12:0] val);
    if (val[12]) begin
      return 12'hFFF;
    end else begin
      return val[11:0];
    end
  endfunction

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          bcnt_q, bcnt_d;
  logic                cand_q, cand_d;
  logic                det_dbl_q, det_dbl_d;
  logic [11:0]         prev_x_q, prev_y_q;
  logic [WD_WIDTH-1:0] wd_q, wd_d;
  logic                line_doubler_q, line_doubler_d;
  logic                capture_en_q, capture_en_d;
  logic                mode_locked_q, mode_locked_d;
  logic                mode_change_q, mode_change_d;
  logic [11:0]         line_len_q, line_len_d;
  logic [11:0]         frame_lines_q, frame_lines_d;

  logic [12:0] x_inc_s, y_inc_s;
  logic        line_end_s, frame_end_s, valid_s, class_s, wd_hit_s;

  // Line/frame event detection and watchdog expiry from the previous counter values.
  always_comb begin
    x_inc_s     = {1'b0, prev_x_q} + 13'd1;
    y_inc_s     = {1'b0, prev_y_q} + 13'd1;
    line_end_s  = (counterX < prev_x_q);
    frame_end_s = line_end_s && (counterY == 12'd0) && (prev_y_q != 12'd0);
    valid_s     = (y_inc_s >= V_MIN_C);
    class_s     = (x_inc_s >= H_TH_C);
    wd_hit_s    = (wd_q == WD_MAX) && !frame_end_s;
  end

  // Mode state machine: acquire a run of same-class frames, blank, then hold lock.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bcnt_d    = bcnt_q;
    cand_d    = cand_q;
    det_dbl_d = det_dbl_q;
    if (wd_hit_s) begin
      state_d = ST_ACQUIRE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ST_ACQUIRE: begin
          if (frame_end_s && valid_s) begin
            if (class_s == cand_q) begin
              cnt_d = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;
            end else begin
              cand_d = class_s;
              cnt_d  = 4'd1;
            end
          end else if (frame_end_s) begin
            cnt_d = 4'd0;
          end else begin
            cnt_d = cnt_q;
          end
          // A run of LOCK_FRAMES commits the candidate class to the writer.
          if (cnt_d >= LOCK_C) begin
            det_dbl_d = cand_d;
            bcnt_d    = 4'd0;
            state_d   = ST_BLANK;
          end else begin
            state_d = ST_ACQUIRE;
          end
        end
        ST_BLANK: begin
          if (frame_end_s && (!valid_s || (class_s != det_dbl_q))) begin
            state_d = ST_ACQUIRE;
            cand_d  = class_s;
            cnt_d   = valid_s ? 4'd1 : 4'd0;
          end else if (frame_end_s) begin
            bcnt_d  = bcnt_q + 4'd1;
            state_d = (bcnt_d >= BLANK_C) ? ST_LOCKED : ST_BLANK;
          end else begin
            state_d = (bcnt_q >= BLANK_C) ? ST_LOCKED : ST_BLANK;
          end
        end
        ST_LOCKED: begin
          if (frame_end_s && (!valid_s || (class_s != det_dbl_q))) begin
            state_d = ST_ACQUIRE;
            cand_d  = class_s;
            cnt_d   = valid_s ? 4'd1 : 4'd0;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: begin
          state_d = ST_ACQUIRE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Next values of the registered outputs, measurements and watchdog.
  always_comb begin
`ifdef CAPTURE_MODE_OVERRIDE_EN
    if (force_en) begin
      line_doubler_d = force_doubler;
      capture_en_d   = 1'b1;
    end else begin
      line_doubler_d = det_dbl_d;
      capture_en_d   = (state_d == ST_LOCKED);
    end
`else
    line_doubler_d = det_dbl_d;
    capture_en_d   = (state_d == ST_LOCKED);
`endif
    mode_locked_d = (state_d != ST_ACQUIRE);
    mode_change_d = (line_doubler_d != line_doubler_q);
    if (line_end_s) begin
      line_len_d = sat12(x_inc_s);
    end else begin
      line_len_d = line_len_q;
    end
    if (frame_end_s) begin
      frame_lines_d = sat12(y_inc_s);
    end else begin
      frame_lines_d = frame_lines_q;
    end
    // The watchdog parks at its maximum so a stalled input keeps forcing ACQUIRE.
    if (frame_end_s) begin
      wd_d = {WD_WIDTH{1'b0}};
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + WD_ONE;
    end else begin
      wd_d = wd_q;
    end
  end

  // State, measurement and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_ACQUIRE;
      cnt_q          <= 4'd0;
      bcnt_q         <= 4'd0;
      cand_q         <= 1'b0;
      det_dbl_q      <= 1'b0;
      prev_x_q       <= 12'd0;
      prev_y_q       <= 12'd0;
      wd_q           <= {WD_WIDTH{1'b0}};
      line_doubler_q <= 1'b0;
      capture_en_q   <= 1'b0;
      mode_locked_q  <= 1'b0;
      mode_change_q  <= 1'b0;
      line_len_q     <= 12'd0;
      frame_lines_q  <= 12'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bcnt_q         <= bcnt_d;
      cand_q         <= cand_d;
      det_dbl_q      <= det_dbl_d;
      prev_x_q       <= counterX;
      prev_y_q       <= counterY;
      wd_q           <= wd_d;
      line_doubler_q <= line_doubler_d;
      capture_en_q   <= capture_en_d;
      mode_locked_q  <= mode_locked_d;
      mode_change_q  <= mode_change_d;
      line_len_q     <= line_len_d;
      frame_lines_q  <= frame_lines_d;
    end
  end

  assign line_doubler = line_doubler_q;
  assign capture_en   = capture_en_q;
  assign mode_locked  = mode_locked_q;
  assign mode_change  = mode_change_q;
  assign line_len     = line_len_q;
  assign frame_lines  = frame_lines_q;

endmodule

// File: doc/capture_mode_ctrl.md
# capture_mode_ctrl

- Configuration controller for the capture path; sits between the video timing generator and the line-buffer writer.
- Measures line length and lines per frame from the running `counterX`/`counterY`.
- Classifies the input as 31 kHz (480p) or 15 kHz (240p/480i) and drives the writer's `line_doubler` select.
- Gates capture with `capture_en` so the writer never fills the buffer during a mode change or while the input is unstable.

## Interface
**Clocking and reset:** one clock; reset is asynchronous and active-low (`clock`, `reset_n`).

Parameters:
- `H_THRESHOLD`, 1200: line length in clocks at or above which a frame classifies as 15 kHz (`line_doubler`=1).
- `V_MIN_LINES`, 200: minimum lines per frame for a frame to be valid.
- `LOCK_FRAMES`, 4: consecutive same-class valid frames required to lock, range 1..15.
- `BLANK_FRAMES`, 2: frames with capture held off after a lock, range 0..15.

Ports:
- `clock` in 1: pixel clock.
- `reset_n` in 1: asynchronous active-low reset.
- `counterX` in 12: horizontal position from the timing generator.
- `counterY` in 12: vertical position from the timing generator.
- `line_doubler` out 1: mode select to the writer; 1 = 15 kHz.
- `capture_en` out 1: writer may write.
- `mode_locked` out 1: classification stable.
- `mode_change` out 1: one-clock pulse when `line_doubler` toggles.
- `line_len` out 12: last measured line length.
- `frame_lines` out 12: last measured lines per frame.

## Operation
Event detection:
- `prevX` and `prevY` are registered copies of the counters.
- **Line end:** `counterX < prevX`. Then `line_len` ← `prevX`+1, saturating at 4095.
- **Frame end:** a line end with `counterY == 0` and `prevY != 0`. Then `frame_lines` ← `prevY`+1.
- **Valid frame:** `prevY`+1 ≥ `V_MIN_LINES`.
- **Frame class:** (`prevX`+1 ≥ `H_THRESHOLD`), using the last line of the frame.
- Candidate-run counter `cnt` is 4 bits.

ACQUIRE state:
- Outputs: `capture_en`=0, `mode_locked`=0.
- On a valid frame: if its class equals `cand`, `cnt`++; otherwise `cand` ← class and `cnt` ← 1.
- On an invalid frame: `cnt` ← 0.
- When `cnt` reaches `LOCK_FRAMES`: `line_doubler` ← `cand`; if the value changed, pulse `mode_change`; `bcnt` ← 0; go to BLANK.

BLANK state:
- Outputs: `capture_en`=0, `mode_locked`=1.
- Each frame end increments `bcnt`.
- At `bcnt == BLANK_FRAMES`, go to LOCKED. With `BLANK_FRAMES`=0, go to LOCKED on the clock after the lock.
- An invalid frame, or a class different from `line_doubler`, goes to ACQUIRE.

LOCKED state:
- Outputs: `capture_en`=1, `mode_locked`=1.
- An invalid frame or a class mismatch goes to ACQUIRE. On that transition `cand` ← class, and `cnt` ← 1 if the frame is valid, else 0.

Watchdog:
- A 20-bit counter clears on every frame end.
- On reaching 2^20−1 it forces ACQUIRE with `cnt`=0, then holds at that value until the next frame end.
- Covers a stalled timing generator.

Other rules:
- **Stability on leaving lock:** `line_doubler` keeps its value in ACQUIRE. It changes only on lock.
- **Reset values:** `line_doubler`=0, `capture_en`=0, `mode_locked`=0, `mode_change`=0, `line_len`=0, `frame_lines`=0. State = ACQUIRE; `cnt`, `bcnt`, `cand` and the watchdog are 0.
- **Reset during operation:** the asynchronous assert returns all of the above values immediately, regardless of state.

## Timing
- All outputs are registered.
- Detection uses the cycle where `counterX < prevX`. `line_len`, `frame_lines`, state and the outputs update on the following edge (1-clock latency).
- `capture_en` falls on the same edge that enters ACQUIRE. The writer therefore sees at most 1 cycle of capture into the offending frame's first line.
- `mode_change` is high for exactly 1 clock, coincident with the new `line_doubler` value.
- If the watchdog and a frame end occur in the same cycle, the frame end wins and the watchdog clears.

## Configuration
Macro: `CAPTURE_MODE_OVERRIDE_EN`.

When defined:
- Adds input ports `force_en` (1 bit) and `force_doubler` (1 bit).
- While `force_en`=1, `line_doubler` is registered from `force_doubler` and `capture_en`=1.
- `mode_change` pulses on any toggle of `line_doubler`.
- Detection, `line_len`, `frame_lines`, `mode_locked` and the state machine keep running.
- When `force_en` deasserts, the outputs revert to state-machine control on the next edge.

When not defined:
- The ports do not exist.
- Behaviour is purely detected.

## Test plan
- **480p lock:** after reset, 858×525 timing for 6 frames. `line_len`=858, `frame_lines`=525. `mode_locked`=1 at the end of frame 4. `capture_en`=1 after 2 further frames. `line_doubler`=0 and `mode_change` never pulses.
- **Switch to 15 kHz:** locked 480p, then 1716×263 frames. `capture_en`=0 one clock after the first such frame end. After 4 frames, `line_doubler`=1 with a 1-clock `mode_change`. `capture_en`=1 after 2 more frames.
- **Invalid frame:** a 100-line frame inserted while locked forces ACQUIRE with `cnt`=0. Relock needs 4 good frames.
- **Stalled timing:** hold `counterX` and `counterY` constant for 2^20 clocks while locked. `capture_en` and `mode_locked` = 0, `line_doubler` unchanged.
- **Reset during BLANK:** assert `reset_n`=0 mid-frame. All outputs are 0 immediately, and the full 4+2 frame sequence repeats.
- **Override (`CAPTURE_MODE_OVERRIDE_EN`):** `force_en`=1, `force_doubler`=1 on 480p input. Next edge gives `line_doubler`=1, `capture_en`=1 and a `mode_change` pulse, while `line_len` still reads 858.
